maj_bist_ctrl: RTL and testbench

On-chip exhaustive stimulus generator and response checker for a mapped N-input majority netlist. It drives every input combination 0 … 2^N-1 onto the DUT inputs and samples the DUT output after a fixed settle time. Each sample is compared against a popcount-threshold reference. The block counts mismatches and reports pass/fail through a start/done handshake. It is the hardware counterpart of the simulation-only exhaustive bench, so mapped majority variants can be checked in FPGA/silicon.

---
 rtl/maj_bist_pkg.sv | 22 ++
 rtl/maj_ref_popcount.sv | 26 ++
 rtl/maj_bist_ctrl.sv | 102 ++++++++++
 tb/tb_maj_bist_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/maj_bist_pkg.sv
// Shared types and constants for the majority-gate BIST controller family.
// Holds the FSM state encoding, a width helper and the default gate size.
package maj_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int DEF_N      = 15;
  localparam int DEF_THRESH = (DEF_N + 1) / 2;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/maj_ref_popcount.sv
// Combinational reference for threshold gates: output is 1 when the
// number of set input bits reaches THRESH.
module maj_ref_popcount
  import maj_bist_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int THRESH = (N + 1) / 2
) (
  input  logic [N-1:0] vec,
  output logic         ref_out
);

  localparam int PW = clog2(N + 1);

  logic [PW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + PW'(vec[i]);
    end
  end

  assign ref_out = (ones >= PW'(THRESH));

endmodule

// File: rtl/maj_bist_ctrl.sv
// Exhaustive stimulus generator and response checker for an N-input
// majority netlist, with start/done handshake and first-failure capture.
module maj_bist_ctrl
  import maj_bist_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int THRESH = (N + 1) / 2,
  parameter int LAT    = 1,
  parameter int ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N-1:0]     x_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [N-1:0]     first_fail_vec
);

  localparam int CW = (clog2(LAT) < 1) ? 1 : clog2(LAT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ref_bit;
  logic          mismatch;

  maj_ref_popcount #(.N(N), .THRESH(THRESH)) u_ref (
    .vec    (x_out),
    .ref_out(ref_bit)
  );

  assign mismatch = (y_in != ref_bit);
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      x_out            <= '0;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (abort) begin
      // Partial results are deliberately kept for debug after an abort.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= SETTLE;
            x_out            <= '0;
            cnt              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        SETTLE: begin
          if (cnt == CW'(LAT - 1)) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != {ERR_W{1'b1}}) begin
              err_count <= err_count + 1'b1;
            end
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= x_out;
            end
          end
          // Terminal vector is detected explicitly so x_out never wraps.
          if (x_out == {N{1'b1}}) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            x_out <= x_out + 1'b1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maj_bist_ctrl.sv
// Bench for maj_bist_ctrl: four instances (N=15 golden, N=15 single fault,
// N=3 LAT=3, N=3 with 2-bit error counter) against a sweep-arithmetic model.
module tb_maj_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      if (bad <= 20) $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endfunction

  // mode 0: golden majority, 1: output stuck at 0, 2: wrong only at vector 0x00FF
  function automatic logic yfun(int m, int n, int v);
    logic g;
    g = ($countones(v) >= (n + 1) / 2);
    case (m)
      1:       return 1'b0;
      2:       return (v == 255) ? 1'b0 : g;
      default: return g;
    endcase
  endfunction

  int nn[4]   = '{15, 15, 3, 3};
  int lat[4]  = '{1, 1, 3, 1};
  int emax[4] = '{65535, 65535, 65535, 3};

  logic st[4];
  logic ab[4];
  int   md[4];

  logic [14:0] x0, x1, f0, f1;
  logic [2:0]  x2, x3, f2, f3;
  logic [15:0] e0, e1, e2;
  logic [1:0]  e3;
  logic        y0, y1, y2, y3;
  logic        bz[4], dn[4], ps[4], fv[4];

  assign y0 = yfun(md[0], 15, int'(x0));
  assign y1 = yfun(md[1], 15, int'(x1));
  assign y2 = yfun(md[2], 3, int'(x2));
  assign y3 = yfun(md[3], 3, int'(x3));

  maj_bist_ctrl #(.N(15), .LAT(1), .ERR_W(16)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .x_out(x0), .y_in(y0),
    .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(e0),
    .first_fail_valid(fv[0]), .first_fail_vec(f0));
  maj_bist_ctrl #(.N(15), .LAT(1), .ERR_W(16)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .x_out(x1), .y_in(y1),
    .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(e1),
    .first_fail_valid(fv[1]), .first_fail_vec(f1));
  maj_bist_ctrl #(.N(3), .LAT(3), .ERR_W(16)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .abort(ab[2]), .x_out(x2), .y_in(y2),
    .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(e2),
    .first_fail_valid(fv[2]), .first_fail_vec(f2));
  maj_bist_ctrl #(.N(3), .LAT(1), .ERR_W(2)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .abort(ab[3]), .x_out(x3), .y_in(y3),
    .busy(bz[3]), .done(dn[3]), .pass(ps[3]), .err_count(e3),
    .first_fail_valid(fv[3]), .first_fail_vec(f3));

  int ax[4], ae[4], af[4];
  always_comb begin
    ax[0] = int'(x0); ax[1] = int'(x1); ax[2] = int'(x2); ax[3] = int'(x3);
    ae[0] = int'(e0); ae[1] = int'(e1); ae[2] = int'(e2); ae[3] = int'(e3);
    af[0] = int'(f0); af[1] = int'(f1); af[2] = int'(f2); af[3] = int'(f3);
  end

  // Model: ph 0 idle, 1 sweeping, 2 done; kk = edges since the start edge.
  // Vector index is kk/(LAT+1); the last cycle of each slot is the check.
  int ph[4], kk[4], merr[4], mffv[4], mffvec[4], mxo[4];

  always @(posedge clk or posedge rst) begin
    int v;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        ph[i] = 0; kk[i] = 0; merr[i] = 0; mffv[i] = 0; mffvec[i] = 0; mxo[i] = 0;
      end else if (ab[i]) begin
        ph[i] = 0;
      end else if (ph[i] != 1 && st[i]) begin
        ph[i] = 1; kk[i] = 0; mxo[i] = 0; merr[i] = 0; mffv[i] = 0; mffvec[i] = 0;
      end else if (ph[i] == 1) begin
        v = kk[i] / (lat[i] + 1);
        if (kk[i] % (lat[i] + 1) == lat[i]) begin
          if (yfun(md[i], nn[i], v) != ($countones(v) >= (nn[i] + 1) / 2)) begin
            if (merr[i] < emax[i]) merr[i]++;
            if (mffv[i] == 0) begin
              mffv[i] = 1;
              mffvec[i] = v;
            end
          end
          if (v == (1 << nn[i]) - 1) ph[i] = 2;
          else mxo[i] = v + 1;
        end
        kk[i]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_x_out", i), ax[i], mxo[i]);
      chk($sformatf("u%0d_busy", i), int'(bz[i]), int'(ph[i] == 1));
      chk($sformatf("u%0d_done", i), int'(dn[i]), int'(ph[i] == 2));
      chk($sformatf("u%0d_pass", i), int'(ps[i]), int'(ph[i] == 2 && merr[i] == 0));
      chk($sformatf("u%0d_err", i), ae[i], merr[i]);
      chk($sformatf("u%0d_ffv", i), int'(fv[i]), mffv[i]);
      chk($sformatf("u%0d_ffvec", i), af[i], mffvec[i]);
    end
  end

  task automatic pulse_start(int i);
    @(negedge clk) st[i] = 1'b1;
    @(negedge clk) st[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int lim, output int cyc);
    cyc = 0;
    while (!dn[i] && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("u%0d_done_timeout", i), int'(dn[i]), 1);
  endtask

  initial begin
    int c0, c1, c2, c3, dat;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; md[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_x_out", ax[0], 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[2]), 0);
    chk("rst_err", ae[1], 0);
    rst = 1'b0;

    fork
      begin
        pulse_start(0);
        wait_done(0, 70000, c0);
        chk("golden15_cycles", c0, 65536);
        chk("golden15_pass", int'(ps[0]), 1);
        chk("golden15_err", ae[0], 0);
        chk("golden15_ffv", int'(fv[0]), 0);
        chk("golden15_x_last", ax[0], 32'h7FFF);
      end
      begin
        md[1] = 2;
        pulse_start(1);
        wait_done(1, 70000, c1);
        chk("fault15_pass", int'(ps[1]), 0);
        chk("fault15_err", ae[1], 1);
        chk("fault15_ffvec", af[1], 32'h00FF);
      end
      begin
        // N=3, LAT=3: vector every 4 cycles, done after 32; mid-sweep start ignored
        pulse_start(2);
        dat = 0;
        for (int m = 1; m <= 40; m++) begin
          @(negedge clk);
          if (m == 3) chk("lat3_x_m3", ax[2], 0);
          if (m == 4) chk("lat3_x_m4", ax[2], 1);
          if (m == 9) st[2] = 1'b1;
          if (m == 10) st[2] = 1'b0;
          if (m == 31) chk("lat3_done_m31", int'(dn[2]), 0);
          if (dn[2] && dat == 0) dat = m;
        end
        chk("lat3_done_cycle", dat, 32);
        chk("lat3_pass", int'(ps[2]), 1);

        md[2] = 1;
        pulse_start(2);
        wait_done(2, 100, c2);
        chk("stuck3_err", ae[2], 4);
        chk("stuck3_ffvec", af[2], 3);
        chk("stuck3_pass", int'(ps[2]), 0);

        md[3] = 1;
        pulse_start(3);
        wait_done(3, 100, c3);
        chk("sat3_cycles", c3, 16);
        chk("sat3_err", ae[3], 3);
        chk("sat3_ffvec", af[3], 3);

        pulse_start(2);
        repeat (20) @(negedge clk);
        chk("abort_err_before", ae[2], 1);
        ab[2] = 1'b1;
        @(negedge clk) ab[2] = 1'b0;
        chk("abort_busy", int'(bz[2]), 0);
        chk("abort_done", int'(dn[2]), 0);
        chk("abort_pass", int'(ps[2]), 0);
        chk("abort_err_kept", ae[2], 1);
        st[2] = 1'b1; ab[2] = 1'b1;
        @(negedge clk);
        st[2] = 1'b0; ab[2] = 1'b0;
        chk("abort_wins_busy", int'(bz[2]), 0);
        chk("abort_wins_err", ae[2], 1);
        pulse_start(2);
        chk("restart_err_clr", ae[2], 0);
        chk("restart_busy", int'(bz[2]), 1);
        wait_done(2, 100, c2);
        chk("restart_err", ae[2], 4);
      end
    join

    md[2] = 0;
    pulse_start(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_x", ax[2], 0);
    chk("async_rst_busy", int'(bz[2]), 0);
    chk("async_rst_done0", int'(dn[0]), 0);
    chk("async_rst_err1", ae[1], 0);
    chk("async_rst_ffv1", int'(fv[1]), 0);
    @(negedge clk) rst = 1'b0;
    pulse_start(2);
    wait_done(2, 100, c2);
    chk("post_rst_cycles", c2, 32);
    chk("post_rst_pass", int'(ps[2]), 1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
